quantum_timer_multi: RTL and testbench
======================================

QUANTUM_TIMER_MULTI -- requirements
Module: quantum_timer_multi

Interface
REQ-001 SHALL have parameter NUM_PROC, default 4, number of processes with their own quantum.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of quantum values and the down-counter.
REQ-003 SHALL have parameter DEFAULT_QUANTUM, default 16, reset value of every quantum table entry.
REQ-004 SHALL have derived constant PID_W = max(1, clog2(NUM_PROC)).
REQ-005 SHALL have port Clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port Halt, input, 1, processor halted; synchronous abort of timing.
REQ-008 SHALL have port Quantum_flag, input, 1, count enable: a cycle is counted only when high.
REQ-009 SHALL have port Pause, input, 1, process blocked on input; freezes counting.
REQ-010 SHALL have port Start, input, 1, begin a quantum for Proc_Id.
REQ-011 SHALL have port Proc_Id, input, PID_W, process being dispatched.
REQ-012 SHALL have port Switch_Ack, input, 1, scheduler acknowledges preemption.
REQ-013 SHALL have ports Load_En (1), Load_Id (PID_W) and Load_Value (CNT_WIDTH), inputs, quantum table write.
REQ-014 SHALL have port quantum_end, output, 1, one-cycle pulse at expiry.
REQ-015 SHALL have port Preempt, output, 1, level held from expiry until Switch_Ack or Start.
REQ-016 SHALL have ports Remaining (CNT_WIDTH) and Cur_Proc (PID_W), outputs, live count and owning process.
REQ-017 SHALL have port Expire_Total, output, 16, saturating count of expiries since Reset.

Function
REQ-018 SHALL implement states IDLE, COUNTING, PAUSED, EXPIRED.
REQ-019 SHALL apply priority Reset > Halt > Start > Switch_Ack > Pause > count.
REQ-020 Start in any state SHALL load Remaining with table[Proc_Id], latch Cur_Proc, clear Preempt and enter COUNTING next cycle.
REQ-021 In COUNTING with Quantum_flag=1 and Pause=0, Remaining SHALL decrement by 1 per cycle.
REQ-022 On a counted cycle with Remaining==1, next state SHALL be EXPIRED with Remaining=0, quantum_end=1 for exactly that cycle, Preempt=1, and Expire_Total incremented, saturating at 16'hFFFF.
REQ-023 A quantum of Q SHALL therefore end after exactly Q counted cycles.
REQ-024 COUNTING with Pause=1 SHALL enter PAUSED holding Remaining; PAUSED with Pause=0 SHALL return to COUNTING with no lost or extra count.
REQ-025 Quantum_flag=0 SHALL hold Remaining without a state change.
REQ-026 EXPIRED with Switch_Ack=1 SHALL clear Preempt and enter IDLE; Switch_Ack is ignored in other states.
REQ-027 Load_En SHALL write table[Load_Id] only when Load_Value != 0; a zero write is ignored.
REQ-028 A Load in the same cycle as Start to the same id SHALL NOT affect the quantum being started; the running quantum never changes mid-flight.
REQ-029 Halt SHALL force IDLE, Remaining=0, Preempt=0 and quantum_end=0, keeping the table and Expire_Total.
REQ-030 Out-of-range Proc_Id or Load_Id (>= NUM_PROC) SHALL be ignored: no Start and no write.

Reset
REQ-031 Reset SHALL give state IDLE, Remaining=0, Cur_Proc=0, quantum_end=0, Preempt=0, Expire_Total=0, and every table entry = DEFAULT_QUANTUM.
REQ-032 Reset asserted mid-quantum SHALL take effect at the next edge with no expiry pulse.

Structure
REQ-033 Package quantum_pkg SHALL hold the state encoding, DEFAULT_QUANTUM and the Expire_Total width.
REQ-034 The table SHALL be a sub-module quantum_table: NUM_PROC x CNT_WIDTH registers, one write port, one async read port.

Verification
REQ-035 Start id 0 with default table and Quantum_flag=1 constant -> quantum_end pulses exactly 16 cycles later, Preempt high until Switch_Ack, then IDLE.
REQ-036 Load id 2 = 5, Start id 2, Pause high for 3 cycles mid-quantum -> expiry after 5 counted cycles (8 cycles elapsed), Remaining frozen during pause.
REQ-037 Start and Load of the same id in the same cycle (value 3, old 16) -> this quantum is 16; the next Start of that id gives 3.
REQ-038 Halt at Remaining=7 -> IDLE, Remaining=0, no quantum_end; the table still holds its loaded values.
REQ-039 Start during EXPIRED together with Switch_Ack -> COUNTING, Preempt cleared; Expire_Total increments once per expiry and saturates at 16'hFFFF.
REQ-040 Load_Value=0 and Proc_Id=5 with NUM_PROC=4 -> table unchanged and no Start.

Source files
------------

// File: rtl/quantum_pkg.sv
// rtl/quantum_pkg.sv - shared state encoding and constants for the quantum timer
package quantum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_EXPIRED  = 2'd3
    } qt_state_e;

    localparam int DEFAULT_QUANTUM = 16;
    localparam int TOTAL_W         = 16;

endpackage

// File: rtl/quantum_table.sv
// rtl/quantum_table.sv - per-process quantum registers, one write port, one async read port
module quantum_table #(
    parameter int NUM_PROC        = 4,
    parameter int CNT_WIDTH       = 8,
    parameter int PID_W           = 2,
    parameter int DEFAULT_QUANTUM = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 wr_en,
    input  logic [PID_W-1:0]     wr_id,
    input  logic [CNT_WIDTH-1:0] wr_data,
    input  logic [PID_W-1:0]     rd_id,
    output logic [CNT_WIDTH-1:0] rd_data
);

    logic [CNT_WIDTH-1:0] mem_q [NUM_PROC];
    logic [CNT_WIDTH-1:0] mem_d [NUM_PROC];

    // Decoded loops keep ids beyond NUM_PROC from touching or reading any entry.
    always_comb begin
        mem_d   = mem_q;
        rd_data = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (wr_en && wr_id == PID_W'(i)) begin
                mem_d[i] = wr_data;
            end
            if (rd_id == PID_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                mem_q[i] <= CNT_WIDTH'(DEFAULT_QUANTUM);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/quantum_timer_multi.sv
// rtl/quantum_timer_multi.sv - per-process quantum down-counter with preemption request
module quantum_timer_multi #(
    parameter int NUM_PROC          = 4,
    parameter int CNT_WIDTH         = 8,
    parameter int DEFAULT_QUANTUM   = quantum_pkg::DEFAULT_QUANTUM,
    localparam int PID_W            = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            Halt,
    input  logic                            Quantum_flag,
    input  logic                            Pause,
    input  logic                            Start,
    input  logic [PID_W-1:0]                Proc_Id,
    input  logic                            Switch_Ack,
    input  logic                            Load_En,
    input  logic [PID_W-1:0]                Load_Id,
    input  logic [CNT_WIDTH-1:0]            Load_Value,
    output logic                            quantum_end,
    output logic                            Preempt,
    output logic [CNT_WIDTH-1:0]            Remaining,
    output logic [PID_W-1:0]                Cur_Proc,
    output logic [quantum_pkg::TOTAL_W-1:0] Expire_Total
);
    import quantum_pkg::*;

    localparam logic [PID_W:0] NP_EXT = (PID_W + 1)'(NUM_PROC);

    qt_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic [PID_W-1:0]     cur_q, cur_d;
    logic                 qend_q, qend_d;
    logic                 pre_q, pre_d;
    logic [TOTAL_W-1:0]   total_q, total_d;

    logic                 start_ok;
    logic                 wr_en;
    logic [CNT_WIDTH-1:0] tbl_rd;

    assign start_ok = Start && ({1'b0, Proc_Id} < NP_EXT);
    assign wr_en    = Load_En && (Load_Value != '0) && ({1'b0, Load_Id} < NP_EXT);

    // The read is combinational from the pre-edge table, so a same-cycle load never leaks into the start.
    quantum_table #(
        .NUM_PROC        (NUM_PROC),
        .CNT_WIDTH       (CNT_WIDTH),
        .PID_W           (PID_W),
        .DEFAULT_QUANTUM (DEFAULT_QUANTUM)
    ) u_table (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_id   (Load_Id),
        .wr_data (Load_Value),
        .rd_id   (Proc_Id),
        .rd_data (tbl_rd)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cur_d   = cur_q;
        qend_d  = 1'b0;
        pre_d   = pre_q;
        total_d = total_q;
        if (Halt) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            pre_d   = 1'b0;
        end else if (start_ok) begin
            state_d = ST_COUNTING;
            rem_d   = tbl_rd;
            cur_d   = Proc_Id;
            pre_d   = 1'b0;
        end else if (state_q == ST_EXPIRED && Switch_Ack) begin
            state_d = ST_IDLE;
            pre_d   = 1'b0;
        end else if (state_q == ST_COUNTING || state_q == ST_PAUSED) begin
            // Leaving PAUSED counts in the same cycle so a pause costs exactly its own length.
            if (Pause) begin
                state_d = ST_PAUSED;
            end else if (Quantum_flag) begin
                if (rem_q <= CNT_WIDTH'(1)) begin
                    state_d = ST_EXPIRED;
                    rem_d   = '0;
                    qend_d  = 1'b1;
                    pre_d   = 1'b1;
                    total_d = (total_q == '1) ? total_q : total_q + TOTAL_W'(1);
                end else begin
                    state_d = ST_COUNTING;
                    rem_d   = rem_q - CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cur_q   <= '0;
            qend_q  <= 1'b0;
            pre_q   <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cur_q   <= cur_d;
            qend_q  <= qend_d;
            pre_q   <= pre_d;
            total_q <= total_d;
        end
    end

    assign quantum_end  = qend_q;
    assign Preempt      = pre_q;
    assign Remaining    = rem_q;
    assign Cur_Proc     = cur_q;
    assign Expire_Total = total_q;

endmodule

// File: tb/tb_quantum_timer_multi.sv
// tb/tb_quantum_timer_multi.sv - vector table, directed corner sequences and random run against a reference model
module tb_quantum_timer_multi;

    localparam int NP = 5;

    logic       Clock = 1'b0;
    logic       Reset, Halt, Quantum_flag, Pause, Start, Switch_Ack, Load_En;
    logic [2:0] Proc_Id, Load_Id, Cur_Proc;
    logic [7:0] Load_Value, Remaining;
    logic       quantum_end, Preempt;
    logic [15:0] Expire_Total;

    int total_cnt = 0;
    int bad_cnt   = 0;

    int m_rem, m_cur, m_total;
    bit m_act, m_pre, m_qe;
    int m_tbl [NP];

    typedef struct {
        bit rst, hlt, flg, pse, stt;
        int pid;
        bit ack, len;
        int lid, lval;
        bit e_qe, e_pre;
        int e_rem, e_cur;
    } vec_t;

    vec_t vt [16];

    always #5 Clock = ~Clock;

    quantum_timer_multi #(.NUM_PROC(NP), .CNT_WIDTH(8), .DEFAULT_QUANTUM(16)) dut (
        .Clock(Clock), .Reset(Reset), .Halt(Halt), .Quantum_flag(Quantum_flag),
        .Pause(Pause), .Start(Start), .Proc_Id(Proc_Id), .Switch_Ack(Switch_Ack),
        .Load_En(Load_En), .Load_Id(Load_Id), .Load_Value(Load_Value),
        .quantum_end(quantum_end), .Preempt(Preempt), .Remaining(Remaining),
        .Cur_Proc(Cur_Proc), .Expire_Total(Expire_Total)
    );

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic clear_in();
        Reset = 0; Halt = 0; Quantum_flag = 1; Pause = 0; Start = 0;
        Proc_Id = 0; Switch_Ack = 0; Load_En = 0; Load_Id = 0; Load_Value = 0;
    endtask

    // Reference: quantum runs while active, one unit per enabled unpaused cycle, expiry when it hits zero.
    task automatic model_step();
        int pid;
        int lid;
        pid  = int'(Proc_Id);
        lid  = int'(Load_Id);
        m_qe = 0;
        if (Reset) begin
            m_rem = 0; m_cur = 0; m_pre = 0; m_act = 0; m_total = 0;
            foreach (m_tbl[i]) m_tbl[i] = 16;
        end else begin
            if (Halt) begin
                m_act = 0; m_rem = 0; m_pre = 0;
            end else if (Start && pid < NP) begin
                m_rem = m_tbl[pid]; m_cur = pid; m_pre = 0; m_act = 1;
            end else if (Switch_Ack && m_pre) begin
                m_pre = 0;
            end else if (m_act && !Pause && Quantum_flag) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_act = 0; m_pre = 1; m_qe = 1;
                    if (m_total < 65535) m_total = m_total + 1;
                end
            end
            if (Load_En && Load_Value != 0 && lid < NP) m_tbl[lid] = int'(Load_Value);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge Clock);
        #1;
        chk("model_rem",   int'(Remaining),    m_rem);
        chk("model_qend",  int'(quantum_end),  int'(m_qe));
        chk("model_pre",   int'(Preempt),      int'(m_pre));
        chk("model_cur",   int'(Cur_Proc),     m_cur);
        chk("model_total", int'(Expire_Total), m_total);
    endtask

    initial begin
        int n;
        int t0;
        bit seen;
        clear_in();

        //       rst hlt flg pse stt pid ack len lid lval qe pre rem cur
        vt[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0};
        vt[1]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 2,  0, 0,  0, 0};
        vt[2]  = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0,  2, 1};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  2, 1};
        vt[4]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  1, 1};
        vt[5]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1,  0, 1};
        vt[6]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1,  0, 1};
        vt[7]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0,  0, 0,  0, 1};
        vt[8]  = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 0,  0, 0,  2, 1};
        vt[9]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0,  2, 1};
        vt[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  1, 1};
        vt[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 1};
        vt[12] = '{0, 0, 1, 0, 1, 6, 0, 1, 5, 9,  0, 0,  0, 1};
        vt[13] = '{0, 0, 1, 0, 1, 4, 0, 0, 0, 0,  0, 0, 16, 4};
        vt[14] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 4};
        vt[15] = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0,  2, 1};

        for (int i = 0; i < 16; i++) begin
            Reset = vt[i].rst; Halt = vt[i].hlt; Quantum_flag = vt[i].flg; Pause = vt[i].pse;
            Start = vt[i].stt; Proc_Id = 3'(vt[i].pid); Switch_Ack = vt[i].ack;
            Load_En = vt[i].len; Load_Id = 3'(vt[i].lid); Load_Value = 8'(vt[i].lval);
            step();
            chk($sformatf("vec%0d_rem", i),  int'(Remaining),   vt[i].e_rem);
            chk($sformatf("vec%0d_qend", i), int'(quantum_end), int'(vt[i].e_qe));
            chk($sformatf("vec%0d_pre", i),  int'(Preempt),     int'(vt[i].e_pre));
            chk($sformatf("vec%0d_cur", i),  int'(Cur_Proc),    vt[i].e_cur);
        end

        // Default quantum of 16 from reset, preemption held until acknowledged.
        clear_in(); Reset = 1; step();
        chk("rst_total", int'(Expire_Total), 0);
        clear_in(); Start = 1; Proc_Id = 0; step();
        chk("q16_load", int'(Remaining), 16);
        clear_in();
        n = 0; seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            step();
            n = k;
            seen = quantum_end;
        end
        chk("q16_seen", int'(seen), 1);
        chk("q16_cycles", n, 16);
        step(); step();
        chk("q16_qend_one_cycle", int'(quantum_end), 0);
        chk("q16_pre_held", int'(Preempt), 1);
        Switch_Ack = 1; step(); clear_in();
        chk("q16_ack_pre", int'(Preempt), 0);
        chk("q16_total", int'(Expire_Total), 1);

        // Quantum of 5 with a 3-cycle pause: 8 cycles elapsed.
        Load_En = 1; Load_Id = 2; Load_Value = 5; step(); clear_in();
        Start = 1; Proc_Id = 2; step(); clear_in();
        n = 0; seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            Pause = (k >= 3 && k <= 5);
            step();
            if (Pause) chk("pause_frozen", int'(Remaining), 3);
            n = k;
            seen = quantum_end;
        end
        clear_in();
        chk("pause_seen", int'(seen), 1);
        chk("pause_cycles", n, 8);

        // Same-cycle load and start of one id: old value now, new value next time.
        Start = 1; Proc_Id = 3; Load_En = 1; Load_Id = 3; Load_Value = 3; step(); clear_in();
        chk("ld_start_old", int'(Remaining), 16);
        chk("ld_start_pre", int'(Preempt), 0);
        Halt = 1; step(); clear_in();
        Start = 1; Proc_Id = 3; step(); clear_in();
        chk("ld_start_new", int'(Remaining), 3);

        // Halt mid-quantum at 7 remaining.
        Start = 1; Proc_Id = 0; step(); clear_in();
        for (int k = 0; k < 9; k++) step();
        chk("halt_pre_rem", int'(Remaining), 7);
        Halt = 1; step(); clear_in();
        chk("halt_rem", int'(Remaining), 0);
        chk("halt_qend", int'(quantum_end), 0);
        chk("halt_pre", int'(Preempt), 0);
        step();
        chk("halt_idle_rem", int'(Remaining), 0);
        Start = 1; Proc_Id = 2; step(); clear_in();
        chk("halt_tbl_kept", int'(Remaining), 5);

        // Restart from EXPIRED with a simultaneous acknowledge.
        t0 = int'(Expire_Total);
        for (int k = 0; k < 5; k++) step();
        chk("exp_pre", int'(Preempt), 1);
        chk("exp_total_inc", int'(Expire_Total), t0 + 1);
        Start = 1; Proc_Id = 3; Switch_Ack = 1; step(); clear_in();
        chk("exp_restart_rem", int'(Remaining), 3);
        chk("exp_restart_pre", int'(Preempt), 0);
        step();
        chk("exp_counting", int'(Remaining), 2);

        // Out-of-range start and zero load leave everything alone.
        Halt = 1; step(); clear_in();
        Start = 1; Proc_Id = 5; Load_En = 1; Load_Id = 2; Load_Value = 0; step(); clear_in();
        chk("oor_no_start", int'(Remaining), 0);
        Start = 1; Proc_Id = 2; step(); clear_in();
        chk("zero_load_ign", int'(Remaining), 5);

        // Random traffic checked against the model each cycle.
        for (int k = 0; k < 3000; k++) begin
            Reset        = ($urandom_range(0, 199) == 0);
            Halt         = ($urandom_range(0, 59) == 0);
            Quantum_flag = ($urandom_range(0, 9) < 8);
            Pause        = ($urandom_range(0, 9) < 2);
            Start        = ($urandom_range(0, 19) == 0);
            Proc_Id      = 3'($urandom_range(0, 7));
            Switch_Ack   = ($urandom_range(0, 9) < 3);
            Load_En      = ($urandom_range(0, 9) == 0);
            Load_Id      = 3'($urandom_range(0, 7));
            Load_Value   = 8'($urandom_range(0, 6));
            step();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
